// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int FETCH_ILEN = 32;

    // First fetch address after reset unless the top overrides it
    localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = '0;

    // Sequential fetch stride in bytes (one word)
    localparam int unsigned FETCH_STEP = 4;

    // One queue entry: PC, fetched word, misaligned-fetch fault marker
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_ILEN-1:0] instr;
        logic                  fault;
    } fetch_entry_t;

    // Fetch engine run/halt state (halt only reachable with the fault option)
    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with push, pop, flush and
// occupancy count. Pointers wrap modulo DEPTH (DEPTH is a power of two).
// Flush dominates: a same-cycle push or pop is ignored.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type ENTRY_T = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  ENTRY_T                     push_entry,
    input  logic                       pop,
    output ENTRY_T                     head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    ENTRY_T           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage array: written on push, never reset (occupancy qualifies it)
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end with a decoupled prefetch queue.
// Issues sequential word fetches, buffers in-order responses with their PCs,
// and on redirect flushes the queue and drops stale in-flight responses.
// Optional feature macro: FETCH_MISALIGN_FAULT_EN -- a misaligned redirect
// halts fetching and enqueues a single fault entry; without it the redirect
// target's low two bits are cleared and instr_fault is tied low.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              ILEN     = FETCH_ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [ILEN-1:0] resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_fault
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            fault;
    } entry_t;

    function automatic logic [XLEN-1:0] step_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(FETCH_STEP);
    endfunction

    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  resp_pc;
    logic [XLEN-1:0]  redir_pc;
    logic [XLEN-1:0]  fault_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit_used;
    logic             halted;
    logic             fault_push;
    logic             fire;
    logic             resp_ok;
    logic             keep_resp;
    logic             push;
    logic             pop;
    entry_t           push_entry;
    entry_t           head;

`ifdef FETCH_MISALIGN_FAULT_EN
    fetch_state_e state;
    fetch_state_e state_next;
    logic         misaligned;
    logic         fault_pend;

    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_pc   = redirect_pc;

    // Run/halt state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FS_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Every redirect chooses run (aligned) or halt (misaligned); otherwise hold
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = misaligned ? FS_HALT : FS_RUN;
        end
    end

    // One-shot flag: enqueue the fault marker on the cycle after the redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_pend <= 1'b0;
        end else begin
            fault_pend <= misaligned;
        end
    end

    // Faulting PC travels with the one-shot flag
    always_ff @(posedge clk) begin
        if (misaligned) begin
            fault_pc <= redirect_pc;
        end
    end

    assign halted      = (state == FS_HALT);
    assign fault_push  = fault_pend && !redirect_valid;
    assign instr_fault = instr_valid && head.fault;
`else
    logic unused_bits;

    assign redir_pc    = {redirect_pc[XLEN-1:2], 2'b00};
    assign halted      = 1'b0;
    assign fault_push  = 1'b0;
    assign fault_pc    = '0;
    assign instr_fault = 1'b0;
    assign unused_bits = ^{redirect_pc[1:0], head.fault};
`endif

    // Credit: in-flight plus queued fetches never exceed the queue depth,
    // so a returning response always finds a free slot.
    assign credit_used = {1'b0, inflight} + {1'b0, count};
    assign req_valid   = !redirect_valid && !halted && (credit_used < (CNT_W+1)'(DEPTH));
    assign req_addr    = fetch_pc;
    assign fire        = req_valid && req_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign resp_ok     = resp_valid && (inflight != '0);
    assign keep_resp   = resp_ok && (discard == '0) && !redirect_valid;
    assign push        = keep_resp || fault_push;
    assign pop         = instr_valid && instr_ready;

    // Select what enters the queue: fetched word, or the fault marker
    always_comb begin
        push_entry = '{pc: resp_pc, instr: resp_data, fault: 1'b0};
        if (fault_push) begin
            push_entry = '{pc: fault_pc, instr: '0, fault: 1'b1};
        end
    end

    // Fetch/response PCs and the in-flight and discard counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            inflight <= inflight + CNT_W'(fire) - CNT_W'(resp_ok);
            if (redirect_valid) begin
                fetch_pc <= redir_pc;
                resp_pc  <= redir_pc;
                discard  <= inflight - CNT_W'(resp_ok);
            end else begin
                if (fire) begin
                    fetch_pc <= step_pc(fetch_pc);
                end
                if (resp_ok) begin
                    if (discard != '0) begin
                        discard <= discard - CNT_W'(1);
                    end else begin
                        resp_pc <= step_pc(resp_pc);
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: queue-based reference model plus an in-order
// memory model with per-request latency, directed phases and a random phase.
module tb_fetch_prefetch;

    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            req_valid;
    logic            req_ready = 1'b0;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid = 1'b0;
    logic [ILEN-1:0] resp_data = '0;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_fault;

    fetch_prefetch #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC('0)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_fault(instr_fault)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Memory side: outstanding requests with the cycle their response is due
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t memq[$];
    int    cyc = 0;
    int    last_due = 0;

    // Reference model state
    typedef struct packed { logic [31:0] pc; logic [31:0] d; logic f; } ment_t;
    ment_t       mq[$];
    logic [31:0] m_fetch, m_resp, m_fpc;
    int          m_infl, m_disc;
    bit          m_halt, m_fpend;

    // Stimulus knobs
    bit          d_redir, d_ready, d_iready, d_spur;
    logic [31:0] d_rpc;
    int          d_lat;

    // Observation logs
    logic [31:0] fire_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_d[$];
    logic        pop_f[$];
    int          valid_cycles;
    int          first_valid;
    logic        last_req_valid;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] fire_at(input int i);
        return (i < fire_log.size()) ? fire_log[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] pc_at(input int i);
        return (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] d_at(input int i);
        return (i < pop_d.size()) ? pop_d[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        fire_log.delete(); pop_pc.delete(); pop_d.delete(); pop_f.delete();
        valid_cycles = 0;
        first_valid  = -1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch = '0; m_resp = '0; m_fpc = '0;
        m_infl = 0; m_disc = 0; m_halt = 0; m_fpend = 0;
    endtask

    // Advance the model by one clock edge using the rules of the front end
    task automatic model_step(input bit rv, input logic [31:0] rpc, input bit rdy,
                              input bit rsv, input logic [31:0] rsd, input bit ir);
        bit fire, rok, popq;
        fire = !rv && !m_halt && (m_infl + mq.size() < DEPTH) && rdy;
        rok  = rsv && (m_infl > 0);
        popq = ir && (mq.size() != 0);
        if (rv) begin
            mq.delete();
            m_disc = m_infl - int'(rok);
            m_infl = m_infl - int'(rok);
`ifdef FETCH_MISALIGN_FAULT_EN
            m_halt  = (rpc[1:0] != 2'b00);
            m_fpend = m_halt;
            m_fpc   = rpc;
            m_fetch = rpc;
            m_resp  = rpc;
`else
            m_fetch = rpc & 32'hFFFF_FFFC;
            m_resp  = rpc & 32'hFFFF_FFFC;
`endif
        end else begin
            if (popq) void'(mq.pop_front());
            if (m_fpend) begin
                mq.push_back('{pc: m_fpc, d: 32'h0, f: 1'b1});
                m_fpend = 0;
            end
            if (fire) begin
                m_fetch = m_fetch + 32'd4;
                m_infl++;
            end
            if (rok) begin
                m_infl--;
                if (m_disc > 0) m_disc--;
                else begin
                    mq.push_back('{pc: m_resp, d: rsd, f: 1'b0});
                    m_resp = m_resp + 32'd4;
                end
            end
        end
    endtask

    // One clock: drive at negedge, compare #1 later, step model at posedge
    task automatic tick();
        bit          exp_rv, real_resp, dut_fire;
        logic [31:0] dut_addr;
        int          due;
        redirect_valid = d_redir;
        redirect_pc    = d_rpc;
        req_ready      = d_ready;
        instr_ready    = d_iready;
        real_resp  = (memq.size() != 0) && (memq[0].due <= cyc);
        resp_valid = real_resp;
        resp_data  = real_resp ? fdata(memq[0].addr) : 32'($urandom);
        if (!real_resp && d_spur && memq.size() == 0) resp_valid = 1'b1;
        #1;
        exp_rv = !d_redir && !m_halt && (m_infl + mq.size() < DEPTH);
        chk("req_valid", req_valid, exp_rv);
        if (exp_rv) chk("req_addr", req_addr, m_fetch);
        chk("instr_valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("instr_pc", instr_pc, mq[0].pc);
            chk("instr", instr, mq[0].d);
            chk("instr_fault", instr_fault, mq[0].f);
        end else begin
            chk("instr_fault_idle", instr_fault, 1'b0);
        end
        last_req_valid = req_valid;
        dut_fire = req_valid && req_ready;
        dut_addr = req_addr;
        if (dut_fire) fire_log.push_back(req_addr);
        if (instr_valid) begin
            valid_cycles++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (instr_valid && instr_ready) begin
            pop_pc.push_back(instr_pc);
            pop_d.push_back(instr);
            pop_f.push_back(instr_fault);
        end
        @(posedge clk);
        model_step(d_redir, d_rpc, d_ready, resp_valid, resp_data, d_iready);
        if (real_resp) void'(memq.pop_front());
        if (dut_fire) begin
            due = cyc + d_lat;
            if (due < last_due) due = last_due;
            memq.push_back('{addr: dut_addr, due: due});
            last_due = due;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset pulse; ends on a falling edge with reset released
    task automatic do_reset();
        redirect_valid = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; instr_ready = 1'b0;
        d_redir = 0; d_ready = 1; d_iready = 1; d_spur = 0; d_lat = 1; d_rpc = '0;
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_req_valid", req_valid, 1'b1);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_instr_fault", instr_fault, 1'b0);
        model_reset();
        memq.delete();
        last_due = 0;
        cyc = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Zero-wait memory, decode always ready: 1 instruction per cycle
        do_reset();
        clear_logs();
        run(10);
        chk("first_valid_cycle", first_valid, 2);
        valid_cycles = 0;
        run(20);
        chk("throughput", valid_cycles, 20);
        chk("seq_req0", fire_at(0), 32'h0);
        chk("seq_req1", fire_at(1), 32'h4);
        chk("seq_req2", fire_at(2), 32'h8);
        chk("seq_pc0", pc_at(0), 32'h0);
        chk("seq_pc1", pc_at(1), 32'h4);
        chk("seq_pc2", pc_at(2), 32'h8);
        chk("seq_d0", d_at(0), 32'hC3A5_5A3C);
        chk("seq_d1", d_at(1), 32'hC3A1_5A3C);
        chk("seq_d2", d_at(2), 32'hC3AD_5A3C);

        // Decode stalled: credit stops fetching at DEPTH
        do_reset();
        clear_logs();
        d_iready = 0;
        run(10);
        chk("full_req_count", fire_log.size(), DEPTH);
        chk("full_req_valid", last_req_valid, 1'b0);
        d_iready = 1;
        run(4);
        chk("full_pc0", pc_at(0), 32'h0);
        chk("full_pc1", pc_at(1), 32'h4);
        chk("full_pc2", pc_at(2), 32'h8);
        chk("full_pc3", pc_at(3), 32'hC);

        // Three requests in flight, redirect to 0x100
        do_reset();
        clear_logs();
        d_lat = 4;
        run(3);
        d_ready = 0; d_redir = 1; d_rpc = 32'h100;
        run(1);
        d_ready = 1; d_redir = 0;
        run(15);
        chk("redir_req", fire_at(3), 32'h100);
        chk("redir_pc0", pc_at(0), 32'h100);
        chk("redir_d0", d_at(0), 32'hC2A5_5A3C);

        // Redirect coinciding with a response and a pop
        do_reset();
        clear_logs();
        d_lat = 2;
        run(3);
        d_redir = 1; d_rpc = 32'h200;
        run(1);
        d_redir = 0;
        chk("flush_empty", instr_valid, 1'b0);
        run(10);
        chk("coinc_pc0", pc_at(0), 32'h0);
        chk("coinc_pc1", pc_at(1), 32'h200);
        chk("coinc_d1", d_at(1), 32'hC1A5_5A3C);

        // Address wrap at the top of the space
        d_lat = 1; d_redir = 1; d_rpc = 32'hFFFF_FFF8;
        run(1);
        d_redir = 0;
        clear_logs();
        run(10);
        chk("wrap_req0", fire_at(0), 32'hFFFF_FFF8);
        chk("wrap_req1", fire_at(1), 32'hFFFF_FFFC);
        chk("wrap_req2", fire_at(2), 32'h0);
        chk("wrap_pc2", pc_at(2), 32'h0);

        // Misaligned redirect target
        d_redir = 1; d_rpc = 32'h102;
        run(1);
        d_redir = 0;
        clear_logs();
        run(12);
`ifdef FETCH_MISALIGN_FAULT_EN
        chk("halt_no_req", fire_log.size(), 0);
        chk("halt_entries", pop_pc.size(), 1);
        chk("halt_pc", pc_at(0), 32'h102);
        chk("halt_fault", (pop_f.size() != 0) ? pop_f[0] : 1'b0, 1'b1);
        d_redir = 1; d_rpc = 32'h200;
        run(1);
        d_redir = 0;
        clear_logs();
        run(6);
        chk("unhalt_req", fire_at(0), 32'h200);
`else
        chk("align_req", fire_at(0), 32'h100);
        chk("align_pc", pc_at(0), 32'h100);
`endif

        // Randomized traffic against the model
        do_reset();
        clear_logs();
        for (int i = 0; i < 4000; i++) begin
            d_ready  = ($urandom % 4) != 0;
            d_iready = ($urandom % 3) != 0;
            d_lat    = 1 + int'($urandom % 5);
            d_spur   = ($urandom % 10) == 0;
            d_redir  = ($urandom % 25) == 0;
            d_rpc    = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | (32'($urandom) & 32'hF))
                                              : 32'($urandom);
            if (($urandom % 4) != 0) d_rpc[1:0] = 2'b00;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
